// File: rtl/bk_mem_pkg.sv
// Shared types and helpers for the BK-0010 SRAM access sequencer.
package bk_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } mem_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int WAIT_W    = 4;

  // Active-high enable for byte lane idx: every lane on a word access, one lane on a byte access.
  function automatic logic lane_en(input logic byte_acc, input int lane, input int idx, input int nb);
    return !byte_acc || ((lane % nb) == idx);
  endfunction

endpackage

// File: rtl/bk_rr_arbiter.sv
// Combinational requestor arbiter: fixed priority (mode=0) or round-robin from ptr (mode=1).
module bk_rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic              mode,
  input  logic [NPORTS-1:0] eligible,
  input  logic [PW-1:0]     ptr,
  output logic [NPORTS-1:0] grant_oh,
  output logic [PW-1:0]     grant_idx,
  output logic              any_grant,
  output logic [PW-1:0]     next_ptr
);

  int   start;
  int   idx;
  logic found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    next_ptr  = ptr;
    found     = 1'b0;
    idx       = 0;
    start     = mode ? int'(ptr) : 0;
    if (start >= NPORTS) start = 0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = start + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && eligible[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = PW'(idx);
        next_ptr      = (idx + 1 >= NPORTS) ? '0 : PW'(idx + 1);
      end
    end
    any_grant = found;
  end

endmodule

// File: rtl/bk_mem_sequencer.sv
// Multi-port SRAM access sequencer: arbitrates requestors onto one async SRAM with a wait-state cycle.
//   state      | meaning
//   ST_IDLE    | strobes high, grant on ce=1 when a port is eligible
//   ST_ACCESS  | strobes low, count wait states, membusy freezes
//   ST_RECOVER | one cycle with strobes high after reply
module bk_mem_sequencer
  import bk_mem_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int AW          = 18,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 3,
  parameter int ARB_MODE    = ARB_FIXED
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          ce,
  input  logic                                          membusy,
  input  logic [NPORTS-1:0]                             req_rd,
  input  logic [NPORTS-1:0]                             req_wt,
  input  logic [NPORTS-1:0]                             req_byte,
  input  logic [NPORTS*AW-1:0]                          req_addr,
  input  logic [NPORTS*DW-1:0]                          req_wdata,
  output logic [NPORTS-1:0]                             reply,
  output logic [NPORTS*DW-1:0]                          rdata,
  output logic [AW-2:0]                                 ram_addr,
  output logic [DW-1:0]                                 ram_dataw,
  input  logic [DW-1:0]                                 ram_datar,
  output logic                                          ram_oe_n,
  output logic                                          ram_we_n,
  output logic [DW/8-1:0]                               ram_be_n,
  output logic [((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] grant_port
);

  localparam int NB = DW / 8;
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  mem_state_t           state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        win_q, win_d;
  logic                 wr_q, wr_d;
  logic [NPORTS-1:0]    mask_q, mask_d;
  logic [AW-2:0]        addr_d;
  logic [DW-1:0]        dataw_d;
  logic                 oe_n_d, we_n_d;
  logic [NB-1:0]        be_n_d;
  logic [NPORTS-1:0]    reply_d;
  logic [NPORTS*DW-1:0] rdata_d;

  logic [NPORTS-1:0]    eligible, arb_oh;
  logic [PW-1:0]        arb_idx, arb_next;
  logic                 arb_any;
  logic [AW-1:0]        sel_addr;
  logic                 sel_byte;
  logic                 sel_wr;

  assign eligible = (req_rd | req_wt) & ~mask_q;

  bk_rr_arbiter #(.NPORTS(NPORTS), .PW(PW)) u_arb (
    .mode      (ARB_MODE == ARB_RR),
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any_grant (arb_any),
    .next_ptr  (arb_next)
  );

  assign sel_addr = req_addr[arb_idx*AW +: AW];
  assign sel_byte = |(arb_oh & req_byte);
  // A write request wins over a simultaneous read on the same port.
  assign sel_wr   = |(arb_oh & req_wt);

  assign grant_port = win_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    addr_d  = ram_addr;
    dataw_d = ram_dataw;
    oe_n_d  = ram_oe_n;
    we_n_d  = ram_we_n;
    be_n_d  = ram_be_n;
    reply_d = '0;
    rdata_d = rdata;
    case (state_q)
      ST_IDLE: begin
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        mask_d = '0;
        if (ce && arb_any) begin
          win_d   = arb_idx;
          ptr_d   = arb_next;
          wr_d    = sel_wr;
          addr_d  = sel_addr[AW-1:1];
          dataw_d = req_wdata[arb_idx*DW +: DW];
          for (int i = 0; i < NB; i++)
            be_n_d[i] = !lane_en(sel_byte, int'(sel_addr[LW-1:0]), i, NB);
          oe_n_d  = sel_wr;
          we_n_d  = !sel_wr;
          cnt_d   = WAIT_W'(WAIT_STATES);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!membusy) begin
          if (cnt_q == '0) begin
            if (!wr_q) rdata_d[int'(win_q)*DW +: DW] = ram_datar;
            reply_d[win_q] = 1'b1;
            mask_d[win_q]  = 1'b1;
            oe_n_d         = 1'b1;
            we_n_d         = 1'b1;
            be_n_d         = '1;
            state_d        = ST_RECOVER;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        mask_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      wr_q      <= 1'b0;
      mask_q    <= '0;
      ram_addr  <= '0;
      ram_dataw <= '0;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_be_n  <= '1;
      reply     <= '0;
      rdata     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      wr_q      <= wr_d;
      mask_q    <= mask_d;
      ram_addr  <= addr_d;
      ram_dataw <= dataw_d;
      ram_oe_n  <= oe_n_d;
      ram_we_n  <= we_n_d;
      ram_be_n  <= be_n_d;
      reply     <= reply_d;
      rdata     <= rdata_d;
    end
  end

endmodule
